// File: rtl/vga_sync_gen_if.sv
// VGA raster output bundle: syncs, display enable, pixel coordinates, strobes.
// The timing generator drives it; pixel-fetch and colour logic consume it.
interface vga_sync_gen_if #(
    parameter int CW = 10
);

    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output hsync,
        output vsync,
        output de,
        output pix_x,
        output pix_y,
        output line_start,
        output frame_start
    );

    modport slave (
        input hsync,
        input vsync,
        input de,
        input pix_x,
        input pix_y,
        input line_start,
        input frame_start
    );

endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters with a registered decode stage.
// Every output describes the raster position one enabled cycle behind the counters.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           en,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    // raster position counters
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    // end-of-line / end-of-frame detection
    logic h_last;
    logic v_last;

    // combinational decode of the current position
    logic          hs_d;
    logic          vs_d;
    logic          de_d;
    logic [CW-1:0] x_d;
    logic [CW-1:0] y_d;
    logic          ls_d;
    logic          fs_d;

    // registered outputs
    logic          hs_q;
    logic          vs_q;
    logic          de_q;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic          ls_q;
    logic          fs_q;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // advance the raster; v steps only on the last pixel of a line
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // decode syncs, active region, coordinates and strobes
    always_comb begin
        hs_d = SYNC_OFF;
        vs_d = SYNC_OFF;
        de_d = 1'b0;
        x_d  = '0;
        y_d  = '0;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if ((h_cnt >= H_SS) && (h_cnt <= H_SE)) begin
            hs_d = SYNC_ON;
        end
        if ((v_cnt >= V_SS) && (v_cnt <= V_SE)) begin
            vs_d = SYNC_ON;
        end
        if ((h_cnt < H_ACT) && (v_cnt < V_ACT)) begin
            de_d = 1'b1;
            x_d  = h_cnt;
            y_d  = v_cnt;
        end
        ls_d = (h_cnt == '0);
        fs_d = (h_cnt == '0) && (v_cnt == '0);
    end

    // register the decode; a dropped enable freezes everything as-is
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_q <= SYNC_OFF;
            vs_q <= SYNC_OFF;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (en) begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.de          = de_q;
    assign vga.pix_x       = x_q;
    assign vga.pix_y       = y_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a scaled-down raster (16x12 totals).
// Reference raster model feeds a scoreboard; a vector table pins key positions.
module tb_vga_sync_gen;

    localparam int CW       = 5;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int F_TOTAL  = H_TOTAL * V_TOTAL;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic en        = 1'b0;

    vga_sync_gen_if #(.CW(CW)) vga ();

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (1'b0),
        .CW       (CW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .vga       (vga)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
    } out_t;

    typedef struct {
        int   edge_n;
        out_t exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   mh      = 0;
    int   mv      = 0;
    int   edges   = 0;
    out_t q[$];
    out_t last_exp;
    vec_t tbl[$];

    function automatic out_t exp_at(int h, int v);
        out_t o;
        o.hs = !((h >= H_ACTIVE + H_FP) && (h <= H_ACTIVE + H_FP + H_SYNC - 1));
        o.vs = !((v >= V_ACTIVE + V_FP) && (v <= V_ACTIVE + V_FP + V_SYNC - 1));
        o.de = (h < H_ACTIVE) && (v < V_ACTIVE);
        o.x  = o.de ? CW'(h) : '0;
        o.y  = o.de ? CW'(v) : '0;
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic out_t rst_out();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic out_t sample();
        return {vga.hsync, vga.vsync, vga.de, vga.pix_x, vga.pix_y,
                vga.line_start, vga.frame_start};
    endfunction

    function automatic vec_t mk(int e, logic hs, logic vs, logic de,
                                int x, int y, logic ls, logic fs);
        vec_t r;
        r.edge_n = e;
        r.exp.hs = hs;
        r.exp.vs = vs;
        r.exp.de = de;
        r.exp.x  = CW'(x);
        r.exp.y  = CW'(y);
        r.exp.ls = ls;
        r.exp.fs = fs;
        return r;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mh       = 0;
        mv       = 0;
        edges    = 0;
        last_exp = rst_out();
    endtask

    task automatic step(input logic e);
        en = e;
        @(posedge sys_clk);
        if (e) begin
            q.push_back(exp_at(mh, mv));
            mh++;
            if (mh == H_TOTAL) begin
                mh = 0;
                mv++;
                if (mv == V_TOTAL) mv = 0;
            end
            edges++;
        end
        #1;
        if (e) begin
            last_exp = q.pop_front();
            check("scoreboard", sample(), last_exp);
        end else begin
            check("hold", sample(), last_exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   guard;
        int   cnt_de, cnt_hs, cnt_vs, cnt_ls, cnt_fs, max_y;
        int   last_fs, last_ls, bad_gap, fs_gap;
        out_t s;

        tbl.push_back(mk(1,   1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(2,   1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(8,   1, 1, 1, 7, 0, 0, 0));
        tbl.push_back(mk(9,   1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(11,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(13,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(14,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(17,  1, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(81,  1, 1, 1, 0, 5, 1, 0));
        tbl.push_back(mk(88,  1, 1, 1, 7, 5, 0, 0));
        tbl.push_back(mk(97,  1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(129, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(160, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(161, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(192, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(193, 1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(194, 1, 1, 1, 1, 0, 0, 0));

        // reset held with en high
        sys_rst_n = 1'b0;
        en        = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset", sample(), rst_out());
        model_reset();
        #2 sys_rst_n = 1'b1;

        // vector table across a full frame and its wrap
        foreach (tbl[i]) begin
            guard = 0;
            while (edges < tbl[i].edge_n && guard < 1000) begin
                step(1'b1);
                guard++;
            end
            check($sformatf("vec%0d", i), sample(), tbl[i].exp);
        end

        // per-frame totals over one frame period window
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
        cnt_ls = 0; cnt_fs = 0; max_y  = 0;
        for (int i = 0; i < F_TOTAL; i++) begin
            step(1'b1);
            s = sample();
            if (s.de) cnt_de++;
            if (!s.hs) cnt_hs++;
            if (!s.vs) cnt_vs++;
            if (s.ls) cnt_ls++;
            if (s.fs) cnt_fs++;
            if (s.de && int'(s.y) > max_y) max_y = int'(s.y);
        end
        check_int("de_cycles", cnt_de, H_ACTIVE * V_ACTIVE);
        check_int("hsync_low", cnt_hs, H_SYNC * V_TOTAL);
        check_int("vsync_low", cnt_vs, V_SYNC * H_TOTAL);
        check_int("line_starts", cnt_ls, V_TOTAL);
        check_int("frame_starts", cnt_fs, 1);
        check_int("max_pix_y", max_y, V_ACTIVE - 1);

        // strobe periods over two frames
        last_fs = -1; last_ls = -1; bad_gap = 0; fs_gap = 0;
        for (int i = 0; i < 2 * F_TOTAL; i++) begin
            step(1'b1);
            if (vga.line_start) begin
                if (last_ls >= 0 && i - last_ls != H_TOTAL) bad_gap++;
                last_ls = i;
            end
            if (vga.frame_start) begin
                if (last_fs >= 0) fs_gap = i - last_fs;
                last_fs = i;
            end
        end
        check_int("line_period_errs", bad_gap, 0);
        check_int("frame_period", fs_gap, F_TOTAL);

        // enable hold in the middle of an active line
        guard = 0;
        while (!(last_exp.de && last_exp.x == CW'(3)) && guard < 400) begin
            step(1'b1);
            guard++;
        end
        check_int("hold_reach", guard < 400 ? 1 : 0, 1);
        repeat (10) step(1'b0);
        step(1'b1);
        check_int("resume_x", int'(vga.pix_x), 4);
        guard = 0;
        while (!vga.line_start && guard < 100) begin
            step(1'b1);
            guard++;
        end
        check_int("resume_to_line_start", guard, H_TOTAL - 4);

        // asynchronous reset in the middle of a frame
        guard = 0;
        while (!(last_exp.de && last_exp.y == CW'(2)) && guard < 400) begin
            step(1'b1);
            guard++;
        end
        check_int("rst_reach", guard < 400 ? 1 : 0, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst", sample(), rst_out());
        @(posedge sys_clk);
        #1;
        check("rst_held", sample(), rst_out());
        model_reset();
        #2 sys_rst_n = 1'b1;
        step(1'b1);
        check_int("fs_after_rst", int'(vga.frame_start), 1);
        repeat (20) step(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
